// File: rtl/rv_isa_pkg.sv
// RISC-V base-ISA encoding constants, decode format codes and the opcode classifier
// shared by the decode stage and its immediate generator.
package rv_isa_pkg;

  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_ILLEGAL = 3'd7
  } fmt_e;

  // Major opcodes, instr[6:2]
  localparam logic [4:0] OPC_OP        = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
  localparam logic [4:0] OPC_OP_32     = 5'b01110;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
  localparam logic [4:0] OPC_LOAD      = 5'b00000;
  localparam logic [4:0] OPC_STORE     = 5'b01000;
  localparam logic [4:0] OPC_BRANCH    = 5'b11000;
  localparam logic [4:0] OPC_JAL       = 5'b11011;
  localparam logic [4:0] OPC_JALR      = 5'b11001;
  localparam logic [4:0] OPC_LUI       = 5'b01101;
  localparam logic [4:0] OPC_AUIPC     = 5'b00101;
  localparam logic [4:0] OPC_SYSTEM    = 5'b11100;
  localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;

  // Width-independent part of a decoded entry; pc and imm are carried beside it.
  typedef struct packed {
    logic [4:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] func3;
    logic [6:0] func7;
    fmt_e       fmt;
  } dec_fields_t;

  // The *-32 opcodes only exist on RV64; on RV32 they fall through to ILLEGAL.
  function automatic fmt_e classify(input logic [31:0] instr, input logic rv64);
    fmt_e f;
    f = FMT_ILLEGAL;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:2])
        OPC_OP:        f = FMT_R;
        OPC_OP_32:     f = rv64 ? FMT_R : FMT_ILLEGAL;
        OPC_LOAD,
        OPC_OP_IMM,
        OPC_MISC_MEM,
        OPC_JALR,
        OPC_SYSTEM:    f = FMT_I;
        OPC_OP_IMM_32: f = rv64 ? FMT_I : FMT_ILLEGAL;
        OPC_STORE:     f = FMT_S;
        OPC_BRANCH:    f = FMT_B;
        OPC_LUI,
        OPC_AUIPC:     f = FMT_U;
        OPC_JAL:       f = FMT_J;
        default:       f = FMT_ILLEGAL;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/rv_decode_stage_imm_gen.sv
// Combinational immediate assembly: gathers the scattered immediate bits for the
// given format and sign-extends from instr[31] to XLEN.
module rv_imm_gen
  import rv_isa_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Signed cast widens with sign extension when XLEN is 64.
  assign imm = XLEN'(imm32);

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RISC-V decode stage between fetch and register-read, with a 2-entry
// skid buffer so the stage sustains one instruction per cycle under backpressure.
module rv_decode_stage
  import rv_isa_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  localparam logic RV64 = (XLEN == 64);

  // Valid/ready: a transfer happens on a rising edge where valid and ready are both
  // high; a producer holding valid keeps its data stable until that edge, and flush
  // takes priority over any same-cycle input transfer.

  dec_fields_t     dec_f;
  logic [XLEN-1:0] dec_imm;

  assign dec_f.opcode = instr[6:2];
  assign dec_f.rd     = instr[11:7];
  assign dec_f.rs1    = instr[19:15];
  assign dec_f.rs2    = instr[24:20];
  assign dec_f.func3  = instr[14:12];
  assign dec_f.func7  = instr[31:25];
  assign dec_f.fmt    = classify(instr, RV64);

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (instr),
    .fmt   (dec_f.fmt),
    .imm   (dec_imm)
  );

  dec_fields_t     out_f,  skid_f;
  logic [XLEN-1:0] out_pc_q, out_imm_q, skid_pc, skid_imm;
  logic            out_valid_q, skid_valid;
  logic            accept;

  // Without the skid the stage is a plain pipeline register and ready follows the output.
  assign in_ready = SKID_EN ? ~skid_valid : (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
      out_f       <= '0;
      out_pc_q    <= '0;
      out_imm_q   <= '0;
      skid_f      <= '0;
      skid_pc     <= '0;
      skid_imm    <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // Output slot frees up: the older skid entry always goes first.
      if (skid_valid) begin
        out_f       <= skid_f;
        out_pc_q    <= skid_pc;
        out_imm_q   <= skid_imm;
        out_valid_q <= 1'b1;
        skid_valid  <= 1'b0;
      end else if (accept) begin
        out_f       <= dec_f;
        out_pc_q    <= pc;
        out_imm_q   <= dec_imm;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_f     <= dec_f;
      skid_pc    <= pc;
      skid_imm   <= dec_imm;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_opcode  = out_f.opcode;
  assign out_rd      = out_f.rd;
  assign out_rs1     = out_f.rs1;
  assign out_rs2     = out_f.rs2;
  assign out_func3   = out_f.func3;
  assign out_func7   = out_f.func7;
  assign out_fmt     = out_f.fmt;
  assign out_imm     = out_imm_q;
  assign out_illegal = (out_f.fmt == FMT_ILLEGAL);

endmodule
